// File: rtl/capture_slot_scheduler_pkg.sv
// capture_sched_pkg
// Shared types and constants for the capture-slot scheduler.
//   state_t    : scheduler FSM states
//   LFSR_W     : width of the slot-selection LFSR
//   LFSR_TAPS  : Galois tap mask (right-shifting form)
//   lfsr_step  : one Galois LFSR advance
package capture_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PICK   = 3'd1,
    STROBE = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int              LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Right-shift Galois step: the bit shifted out selects the tap mask.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
    return {1'b0, cur[LFSR_W-1:1]} ^ (cur[0] ? LFSR_TAPS : {LFSR_W{1'b0}});
  endfunction

endpackage

// File: rtl/capture_slot_scheduler_if.sv
// capture_slot_scheduler_if
// Control/status bundle between the requesting logic and the scheduler.
//   start, count, clear_all : requests from the controller (master)
//   en                      : per-slot capture enables (one-hot strobes)
//   slot_valid              : slots holding data since the last clear
//   busy, done              : operation status
//   lfsr_state              : debug view of the selection LFSR
interface capture_slot_scheduler_if #(
  parameter int N_SLOTS = 8
) ();
  import capture_sched_pkg::*;

  localparam int CW = $clog2(N_SLOTS + 1);

  logic              start;
  logic [CW-1:0]     count;
  logic              clear_all;
  logic [N_SLOTS-1:0] en;
  logic [N_SLOTS-1:0] slot_valid;
  logic              busy;
  logic              done;
  logic [LFSR_W-1:0] lfsr_state;

  modport master (
    output start, count, clear_all,
    input  en, slot_valid, busy, done, lfsr_state
  );

  modport slave (
    input  start, count, clear_all,
    output en, slot_valid, busy, done, lfsr_state
  );
endinterface

// File: rtl/capture_slot_scheduler_lfsr16_galois.sv
// lfsr16_galois
// 16-bit Galois LFSR that only moves when asked to.
//   clk     : rising-edge clock
//   reset   : synchronous active-high, loads SEED
//   advance : step the register once this cycle
//   state   : current LFSR value
module lfsr16_galois
  import capture_sched_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] r_lfsr;

  // LFSR register: seed on reset, one step per advance request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else if (advance) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end else begin
      r_lfsr <= r_lfsr;
    end
  end

  assign state = r_lfsr;

endmodule

// File: rtl/capture_slot_scheduler.sv
// capture_slot_scheduler
// Fills a requested number of free capture slots in pseudo-random order,
// issuing one single-cycle enable strobe per chosen slot, spaced by
// STROBE_GAP idle cycles.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of capture_slot_scheduler_if
//                (start/count/clear_all in; en/slot_valid/busy/done/lfsr_state out)
module capture_slot_scheduler
  import capture_sched_pkg::*;
#(
  parameter int              N_SLOTS    = 8,
  parameter int              STROBE_GAP = 4,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    reset,
  capture_slot_scheduler_if.slave bus
);

  localparam int SW    = $clog2(N_SLOTS);
  localparam int CW    = $clog2(N_SLOTS + 1);
  localparam int GAP_W = (STROBE_GAP > 1) ? $clog2(STROBE_GAP + 1) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SW-1:0]      r_cand;
  logic [SW-1:0]      w_cand_nxt;
  logic [CW-1:0]      r_remaining;
  logic [CW-1:0]      w_remaining_nxt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic [N_SLOTS-1:0] r_slot_valid;
  logic [N_SLOTS-1:0] w_valid_nxt;
  logic [N_SLOTS-1:0] r_en;
  logic [N_SLOTS-1:0] w_en_nxt;
  logic               r_done;
  logic               r_busy;

  logic [LFSR_W-1:0]  w_lfsr;
  logic [SW-1:0]      w_adv_low;
  logic               w_advance;
  logic [N_SLOTS-1:0] w_valid_cleared;
  logic [CW-1:0]      w_free_cnt;
  logic [CW-1:0]      w_fill_cnt;

  // Number of slots whose valid bit is clear.
  function automatic logic [CW-1:0] count_free(input logic [N_SLOTS-1:0] valid);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!valid[i]) begin
        n = n + CW'(1'b1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // The LFSR steps in the STROBE cycle, so its new value is visible from
  // the following cycle onward.
  assign w_advance = (r_state == STROBE);

  lfsr16_galois #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (w_advance),
    .state   (w_lfsr)
  );

  // With no gap, PICK follows STROBE directly and must already see the
  // post-advance value, so take the low bits of the next LFSR state.
  assign w_adv_low = SW'(lfsr_step(w_lfsr));

  // A same-cycle clear is applied before counting free slots for a start.
  assign w_valid_cleared = bus.clear_all ? {N_SLOTS{1'b0}} : r_slot_valid;
  assign w_free_cnt      = count_free(w_valid_cleared);
  assign w_fill_cnt      = (bus.count < w_free_cnt) ? bus.count : w_free_cnt;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cand_nxt      = r_cand;
    w_remaining_nxt = r_remaining;
    w_gap_nxt       = r_gap_cnt;
    w_valid_nxt     = r_slot_valid;
    w_en_nxt        = {N_SLOTS{1'b0}};
    case (r_state)
      IDLE: begin
        w_valid_nxt = w_valid_cleared;
        if (bus.start) begin
          w_remaining_nxt = w_fill_cnt;
          if (w_fill_cnt == {CW{1'b0}}) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = PICK;
            w_cand_nxt  = w_lfsr[SW-1:0];
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      PICK: begin
        // Linear probing; always finds a slot because remaining <= free.
        if (!r_slot_valid[r_cand]) begin
          w_state_nxt      = STROBE;
          w_en_nxt[r_cand] = 1'b1;
        end else begin
          w_cand_nxt = r_cand + SW'(1'b1);
        end
      end
      STROBE: begin
        w_valid_nxt[r_cand] = 1'b1;
        w_remaining_nxt     = r_remaining - CW'(1'b1);
        if (r_remaining == CW'(1'b1)) begin
          w_state_nxt = DONE;
        end else if (STROBE_GAP == 0) begin
          w_state_nxt = PICK;
          w_cand_nxt  = w_adv_low;
        end else begin
          w_state_nxt = GAP;
          w_gap_nxt   = GAP_W'(STROBE_GAP - 1);
        end
      end
      GAP: begin
        if (r_gap_cnt == {GAP_W{1'b0}}) begin
          w_state_nxt = PICK;
          w_cand_nxt  = w_lfsr[SW-1:0];
        end else begin
          w_gap_nxt = r_gap_cnt - GAP_W'(1'b1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs; en/done/busy are aligned to the state
  // they describe by registering them from the next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand       <= {SW{1'b0}};
      r_remaining  <= {CW{1'b0}};
      r_gap_cnt    <= {GAP_W{1'b0}};
      r_slot_valid <= {N_SLOTS{1'b0}};
      r_en         <= {N_SLOTS{1'b0}};
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_cand       <= w_cand_nxt;
      r_remaining  <= w_remaining_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_slot_valid <= w_valid_nxt;
      r_en         <= w_en_nxt;
      r_done       <= (w_state_nxt == DONE);
      r_busy       <= (w_state_nxt != IDLE);
    end
  end

  assign bus.en         = r_en;
  assign bus.slot_valid = r_slot_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.lfsr_state = w_lfsr;

endmodule

// File: tb/tb_capture_slot_scheduler.sv
module tb_capture_slot_scheduler;

  localparam int GAP = 4;

  typedef struct {
    int         cyc;
    logic [7:0] en;
  } strobe_t;

  logic clk;
  logic reset;

  capture_slot_scheduler_if #(.N_SLOTS(8)) bus ();

  capture_slot_scheduler #(
    .N_SLOTS    (8),
    .STROBE_GAP (GAP),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] m_lfsr;
  logic [7:0]  m_valid;
  strobe_t     q[$];

  function automatic logic [15:0] tb_lfsr_next(input logic [15:0] l);
    logic [15:0] r;
    r = l >> 1;
    if (l[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fill operation: the model pushes expected strobes into the queue,
  // the monitor pops them as en fires and compares slot/cycle.
  task automatic run_op(input int cnt, input bit poke);
    int         free;
    int         rem;
    int         cyc;
    int         cand;
    int         done_cyc;
    bit         finished;
    logic [7:0] v;
    logic [7:0] run_valid;
    strobe_t    s;

    q.delete();
    free = 0;
    for (int i = 0; i < 8; i++) if (!m_valid[i]) free++;
    rem      = (cnt < free) ? cnt : free;
    v        = m_valid;
    cyc      = 1;
    done_cyc = 1;
    while (rem > 0) begin
      cand = int'(m_lfsr[2:0]);
      while (v[cand]) begin
        cand = (cand + 1) % 8;
        cyc++;
      end
      s.cyc = cyc + 1;
      s.en  = 8'h01 << cand;
      q.push_back(s);
      v[cand] = 1'b1;
      m_lfsr  = tb_lfsr_next(m_lfsr);
      rem--;
      if (rem == 0) done_cyc = cyc + 2;
      else          cyc = cyc + 2 + GAP;
    end

    bus.start = 1'b1;
    bus.count = 4'(cnt);
    tick();
    bus.start = 1'b0;
    bus.count = 4'd0;
    run_valid = m_valid;
    finished  = 1'b0;
    for (int k = 1; k <= 200 && !finished; k++) begin
      bus.start     = poke && (k == 3);
      bus.clear_all = poke && (k == 3);
      bus.count     = (poke && (k == 3)) ? 4'd8 : 4'd0;
      chk("busy", bus.busy, 32'(1'b1));
      chk("done", bus.done, 32'(k == done_cyc));
      chk("slot_valid", bus.slot_valid, run_valid);
      if (bus.en !== 8'h00) begin
        if (q.size() == 0) begin
          chk("en_unexpected", bus.en, 32'h0);
        end else begin
          s = q.pop_front();
          chk("en", bus.en, s.en);
          chk("en_cycle", k, s.cyc);
          run_valid = run_valid | s.en;
        end
      end
      if (k == done_cyc) begin
        chk("strobes_left", q.size(), 32'h0);
        finished = 1'b1;
      end
      tick();
    end
    bus.start     = 1'b0;
    bus.clear_all = 1'b0;
    chk("op_finished", finished, 32'(1'b1));
    chk("idle_busy", bus.busy, 32'h0);
    chk("idle_done", bus.done, 32'h0);
    chk("idle_en", bus.en, 32'h0);
    chk("final_valid", bus.slot_valid, v);
    chk("final_lfsr", bus.lfsr_state, m_lfsr);
    m_valid = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_en;

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.count     = 4'd0;
    bus.clear_all = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    m_lfsr  = 16'hACE1;
    m_valid = 8'h00;

    // reset state
    chk("rst_en", bus.en, 32'h0);
    chk("rst_valid", bus.slot_valid, 32'h0);
    chk("rst_busy", bus.busy, 32'h0);
    chk("rst_done", bus.done, 32'h0);
    chk("rst_lfsr", bus.lfsr_state, 32'hACE1);

    // count=2: slot 1 at +2, slot 0 at +8, done at +9
    run_op(2, 1'b0);
    chk("s1_valid", bus.slot_valid, 32'h03);
    chk("s1_lfsr", bus.lfsr_state, 32'h7138);

    // count=1: two failed probes, slot 2 at +4
    run_op(1, 1'b0);
    chk("s2_valid", bus.slot_valid, 32'h07);

    // fill the rest (clamped to 5), then a start with nothing free
    run_op(8, 1'b0);
    chk("full_valid", bus.slot_valid, 32'hFF);
    run_op(3, 1'b0);
    chk("full_valid2", bus.slot_valid, 32'hFF);

    // clear in IDLE
    bus.clear_all = 1'b1;
    tick();
    bus.clear_all = 1'b0;
    chk("clear_valid", bus.slot_valid, 32'h0);
    m_valid = 8'h00;

    // count=8 from empty: eight distinct strobes
    run_op(8, 1'b0);
    chk("fill8_valid", bus.slot_valid, 32'hFF);

    // reset in the middle of GAP
    bus.clear_all = 1'b1;
    tick();
    bus.clear_all = 1'b0;
    m_valid   = 8'h00;
    exp_en    = 8'h01 << m_lfsr[2:0];
    bus.start = 1'b1;
    bus.count = 4'd2;
    tick();
    bus.start = 1'b0;
    bus.count = 4'd0;
    tick();
    chk("mg_first_en", bus.en, exp_en);
    tick();
    tick();
    chk("mg_gap_en", bus.en, 32'h0);
    chk("mg_gap_busy", bus.busy, 32'(1'b1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mg_rst_en", bus.en, 32'h0);
    chk("mg_rst_valid", bus.slot_valid, 32'h0);
    chk("mg_rst_busy", bus.busy, 32'h0);
    chk("mg_rst_done", bus.done, 32'h0);
    chk("mg_rst_lfsr", bus.lfsr_state, 32'hACE1);
    m_lfsr  = 16'hACE1;
    m_valid = 8'h00;

    // after reset the first scenario repeats exactly
    run_op(2, 1'b0);
    chk("rep_valid", bus.slot_valid, 32'h03);
    chk("rep_lfsr", bus.lfsr_state, 32'h7138);

    // start + clear_all pulsed while busy are ignored
    run_op(3, 1'b1);
    chk("poke_busy", bus.busy, 32'h0);
    bus.clear_all = 1'b1;
    tick();
    bus.clear_all = 1'b0;
    chk("poke_clear_valid", bus.slot_valid, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
